// File: rtl/fifo_sdpram_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_sdpram_ctrl
// Synchronous FIFO controller that drives an external simple-dual-port
// distributed RAM with a combinational read port. Both pointers carry one
// extra wrap bit so that full and empty can be told apart when the
// addresses are equal.
//
// Ports
//   clk, rst_n            single rising-edge clock, async active-low reset
//   wr_en, wr_data        write request and word
//   full, almost_full     fill flags (almost_full: level >= ALMOST_FULL_NUM)
//   overflow              1-cycle pulse per write request made while full
//   rd_en                 read request
//   rd_data, rd_valid     registered read word, valid one cycle after rd_ok
//   empty, almost_empty   drain flags (almost_empty: level <= ALMOST_EMPTY_NUM)
//   underflow             1-cycle pulse per read request made while empty
//   wr_water_level        number of stored words, 0..DEPTH
//   ram_wr_en/addr/data   RAM write port, written on the pointer-advance edge
//   ram_rd_addr/data      RAM read port, ram_rd_data is combinational
// ---------------------------------------------------------------------------
module fifo_sdpram_ctrl #(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int ALMOST_FULL_NUM  = (1 << ADDR_WIDTH) - 2,
    parameter int ALMOST_EMPTY_NUM = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   wr_water_level,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_LEVEL  = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] AE_LEVEL  = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

    logic [ADDR_WIDTH:0]   wr_ptr_r;
    logic [ADDR_WIDTH:0]   rd_ptr_r;
    logic [ADDR_WIDTH:0]   level_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  wr_ok_s;
    logic                  rd_ok_s;

    // Flag decode from registered pointers and acceptance of requests.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        // Same address with opposite wrap bits means the writer is a lap ahead.
        if ((wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]) &&
            (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH])) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
        wr_ok_s = wr_en & ~full_s;
        rd_ok_s = rd_en & ~empty_s;
    end

    // Pointer advance; the RAM captures wr_data on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
            rd_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Stored-word count; a simultaneous accepted write and read cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_r <= level_r + PTR_ONE;
                2'b01:   level_r <= level_r - PTR_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Read data register: one-cycle latency, holds the last word when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= {DATA_WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_ok_s;
            if (rd_ok_s) begin
                rd_data_r <= ram_rd_data;
            end
        end
    end

    // Error pulses for requests rejected by the pre-edge flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= wr_en & full_s;
            underflow_r <= rd_en & empty_s;
        end
    end

    assign full           = full_s;
    assign empty          = empty_s;
    assign almost_full    = (level_r >= AF_LEVEL);
    assign almost_empty   = (level_r <= AE_LEVEL);
    assign overflow       = overflow_r;
    assign underflow      = underflow_r;
    assign rd_data        = rd_data_r;
    assign rd_valid       = rd_valid_r;
    assign wr_water_level = level_r;
    assign ram_wr_en      = wr_ok_s;
    assign ram_wr_addr    = wr_ptr_r[ADDR_WIDTH-1:0];
    assign ram_wr_data    = wr_data;
    assign ram_rd_addr    = rd_ptr_r[ADDR_WIDTH-1:0];

endmodule

// File: doc/fifo_sdpram_ctrl.md
FIFO_SDPRAM_CTRL -- requirements
Module: fifo_sdpram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, RAM address width, legal range 4-10; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width, legal range 1-256.
REQ-003 SHALL have parameter ALMOST_FULL_NUM, default DEPTH-2, level at or above which almost_full asserts.
REQ-004 SHALL have parameter ALMOST_EMPTY_NUM, default 2, level at or below which almost_empty asserts.
REQ-005 SHALL have ports: clk  in  1  single clock, all logic rising-edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: wr_en in 1 write request; wr_data in DATA_WIDTH write word; full out 1; almost_full out 1; overflow out 1 write-while-full pulse.
REQ-007 SHALL have ports: rd_en in 1 read request; rd_data out DATA_WIDTH read word; rd_valid out 1 rd_data qualifier; empty out 1; almost_empty out 1; underflow out 1 read-while-empty pulse.
REQ-008 SHALL have port: wr_water_level out ADDR_WIDTH+1 stored word count, 0..DEPTH.
REQ-009 SHALL have RAM-side ports: ram_wr_en out 1; ram_wr_addr out ADDR_WIDTH; ram_wr_data out DATA_WIDTH; ram_rd_addr out ADDR_WIDTH; ram_rd_data in DATA_WIDTH, combinational read of ram_rd_addr (distributed SDPRAM, OUT_REG=0, both RAM clocks tied to clk).

Function
REQ-010 SHALL keep wr_ptr and rd_ptr of ADDR_WIDTH+1 bits; low ADDR_WIDTH bits drive ram_wr_addr / ram_rd_addr directly; MSB is the wrap bit.
REQ-011 SHALL accept a write (wr_ok) iff wr_en=1 and full=0 at the same edge; read accepted (rd_ok) iff rd_en=1 and empty=0; both judged on pre-edge flags.
REQ-012 SHALL drive ram_wr_en = wr_ok combinationally and ram_wr_data = wr_data; RAM captures at the same edge wr_ptr increments.
REQ-013 SHALL increment each pointer by 1 modulo 2**(ADDR_WIDTH+1) on its accepted operation; address wraps DEPTH-1 -> 0, wrap bit toggles.
REQ-014 SHALL register rd_data <= ram_rd_data and rd_valid <= 1 on rd_ok; rd_valid <= 0 otherwise; rd_data holds last value when not reading; read latency exactly 1 cycle.
REQ-015 SHALL maintain wr_water_level as a register: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
REQ-016 SHALL derive from registered state: empty = (wr_ptr==rd_ptr); full = (low bits equal, MSBs differ); almost_full = (level >= ALMOST_FULL_NUM); almost_empty = (level <= ALMOST_EMPTY_NUM).
REQ-017 SHALL, when full and wr_en=rd_en=1, perform read only; write dropped, overflow pulses 1 cycle, full deasserts next cycle.
REQ-018 SHALL, when empty and wr_en=rd_en=1, perform write only (no fall-through); underflow pulses 1 cycle; rd_valid stays 0; empty deasserts next cycle.
REQ-019 SHALL register overflow = wr_en & full and underflow = rd_en & empty, each 1-cycle per offending request; pointers, level and RAM untouched by rejected requests.
REQ-020 SHALL, when neither full nor empty and both requests present, accept both; level unchanged.

Reset
REQ-021 SHALL, on rst_n=0, asynchronously clear wr_ptr, rd_ptr, wr_water_level, rd_data, rd_valid, overflow, underflow to 0; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-022 SHALL, on reset mid-operation, discard all stored words logically (RAM contents not cleared); an in-flight read produces rd_valid=0 after reset.
REQ-023 SHALL leave reset synchronously released by the system; first accepted operation is on the first rising edge with rst_n=1.

Verification
REQ-024 SHALL cover: ADDR_WIDTH=4, write 0x0001..0x0010 (16 words) -> full=1 after 16th, level=16, almost_full=1 from level 14; 17th write -> overflow 1-cycle pulse, level stays 16.
REQ-025 SHALL cover: read all 16 -> rd_data 0x0001..0x0010 in order, rd_valid each following cycle, empty=1 after last; extra read -> underflow pulse, rd_valid=0.
REQ-026 SHALL cover: 40 writes/reads interleaved with level held at 3 -> pointers wrap twice, data order intact, wrap bit toggles at address 15->0.
REQ-027 SHALL cover: full + simultaneous wr_en/rd_en -> read only, overflow=1, level 16->15; empty + simultaneous -> write only, underflow=1, level 0->1.
REQ-028 SHALL cover: rst_n low for 1 cycle with level=9 and rd_en=1 -> all outputs to reset values asynchronously, next write/read returns the newly written word.
